// File: rtl/a1339_pkg.sv
// Shared definitions for the A1339 angle-sensor SPI emulator and its master-side decoder.
package a1339_pkg;

    localparam logic [19:0] CMD_ANGLE  = 20'h20009;
    localparam logic [19:0] CMD_TURNS  = 20'h2C001;
    localparam logic [15:0] ERROR_DATA = 16'h8000;
    localparam logic [19:0] TX_RESET   = 20'h0000D;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // x^4+x+1, seed 4'hF, data MSB first
    function automatic logic [3:0] crc4(input logic [15:0] data);
        logic [3:0] c;
        logic       d;
        c = 4'hF;
        for (int i = 15; i >= 0; i--) begin
            d = data[i] ^ c[3];
            c = {c[2], c[1], c[0] ^ d, d};
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detection on the synchronized level.
module spi_slave_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;

    always_comb begin
        chain_d[0] = din_i;
        for (int i = 1; i < STAGES; i++) chain_d[i] = chain_q[i-1];
        prev_d = chain_q[STAGES-1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/a1339_emulator.sv
// SPI mode-3 slave emulating an A1339 sensor: captures commands, answers one frame later with CRC-protected data.
module a1339_emulator
    import a1339_pkg::*;
#(
    parameter int FRAME_BITS  = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sck_i,
    input  logic                  ss_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe,
    input  logic [11:0]           angle_i,
    input  logic [11:0]           turns_i,
    output logic [FRAME_BITS-1:0] cmd_o,
    output logic                  cmd_valid_o,
    output logic [15:0]           abort_count_o
);

    localparam int BCW = $clog2(FRAME_BITS + 1);
    localparam logic [BCW-1:0] FULL = BCW'(FRAME_BITS);

    logic sck_sync, sck_rise, sck_fall;
    logic ss_sync, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
        .clock(clock), .reset(reset), .din_i(sck_i),
        .sync_o(sck_sync), .rise_o(sck_rise), .fall_o(sck_fall));
    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clock(clock), .reset(reset), .din_i(ss_n_i),
        .sync_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall));
    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .din_i(mosi_i),
        .sync_o(mosi_sync), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0]   tx_shadow_q, tx_shadow_d;
    logic [FRAME_BITS-1:0]   cmd_q, cmd_d;
    logic [BCW-1:0]          bit_count_q, bit_count_d;
    logic [15:0]             abort_count_q, abort_count_d;
    logic                    miso_q, miso_d;
    logic [SYNC_STAGES:0]    warm_q, warm_d;
    logic                    armed_q, armed_d;
    logic                    start;
    logic [15:0]             data;

    // An SS already low when reset releases must not start a frame: wait until
    // the synchronizer has flushed and shows SS high before honouring a fall.
    always_comb begin
        warm_d  = {warm_q[SYNC_STAGES-1:0], 1'b1};
        armed_d = armed_q | (warm_q[SYNC_STAGES] & ss_sync);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall && armed_q) state_d = SHIFT;
            SHIFT:   if (ss_rise) state_d = (bit_count_q == FULL) ? DONE : IDLE;
            DONE:    state_d = ss_fall ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        tx_shadow_d   = tx_shadow_q;
        cmd_d         = cmd_q;
        bit_count_d   = bit_count_q;
        abort_count_d = abort_count_q;
        miso_d        = miso_q;
        data          = ERROR_DATA;
        start         = ss_fall && ((state_q == IDLE && armed_q) || state_q == DONE);

        if (state_q == SHIFT) begin
            if (sck_fall) begin
                miso_d     = (bit_count_q == FULL) ? 1'b0 : tx_shift_q[FRAME_BITS-1];
                tx_shift_d = tx_shift_q << 1;
            end
            if (sck_rise && bit_count_q != FULL) begin
                rx_shift_d  = {rx_shift_q[FRAME_BITS-2:0], mosi_sync};
                bit_count_d = bit_count_q + BCW'(1);
            end
            if (ss_rise) begin
                if (bit_count_q == FULL) cmd_d = rx_shift_q;
                else                     abort_count_d = abort_count_q + 16'd1;
            end
        end

        if (state_q == DONE) begin
            if (rx_shift_q == FRAME_BITS'(CMD_ANGLE))      data = {4'h0, angle_i};
            else if (rx_shift_q == FRAME_BITS'(CMD_TURNS)) data = {4'h0, turns_i};
            tx_shadow_d = FRAME_BITS'({data, crc4(data)});
        end

        // A fall coinciding with DONE picks up the shadow being built this cycle.
        if (start) begin
            tx_shift_d  = (state_q == DONE) ? tx_shadow_d : tx_shadow_q;
            rx_shift_d  = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            tx_shadow_q   <= FRAME_BITS'(TX_RESET);
            cmd_q         <= '0;
            bit_count_q   <= '0;
            abort_count_q <= '0;
            miso_q        <= 1'b0;
            warm_q        <= '0;
            armed_q       <= 1'b0;
        end else begin
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            tx_shadow_q   <= tx_shadow_d;
            cmd_q         <= cmd_d;
            bit_count_q   <= bit_count_d;
            abort_count_q <= abort_count_d;
            miso_q        <= miso_d;
            warm_q        <= warm_d;
            armed_q       <= armed_d;
        end
    end

    always_comb begin
        cmd_valid_o   = (state_q == DONE);
        miso_o        = miso_q;
        miso_oe       = ~ss_sync;
        cmd_o         = cmd_q;
        abort_count_o = abort_count_q;
    end

endmodule

// File: tb/tb_a1339_emulator.sv
// Directed bench for a1339_emulator: SPI master model with a response scoreboard and CRC check.
module tb_a1339_emulator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sck_i = 1'b1;
    logic        ss_n_i = 1'b1;
    logic        mosi_i = 1'b0;
    logic        miso_o, miso_oe, cmd_valid_o;
    logic [11:0] angle_i = '0;
    logic [11:0] turns_i = '0;
    logic [19:0] cmd_o;
    logic [15:0] abort_count_o;

    a1339_emulator #(.FRAME_BITS(20), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .sck_i(sck_i), .ss_n_i(ss_n_i),
        .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe(miso_oe),
        .angle_i(angle_i), .turns_i(turns_i), .cmd_o(cmd_o),
        .cmd_valid_o(cmd_valid_o), .abort_count_o(abort_count_o));

    always #5 clock = ~clock;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          vld_cnt  = 0;
    logic [19:0] exp_q[$];
    logic [19:0] model_shadow;

    always @(negedge clock) if (cmd_valid_o === 1'b1) vld_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] tb_crc(input logic [15:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'hF;
        for (int i = 15; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = (c << 1) ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    function automatic logic [19:0] exp_resp(input logic [19:0] cmd, input logic [11:0] ang,
                                             input logic [11:0] trn);
        logic [15:0] d;
        if (cmd == 20'h20009)      d = {4'h0, ang};
        else if (cmd == 20'h2C001) d = {4'h0, trn};
        else                       d = 16'h8000;
        return {d, tb_crc(d)};
    endfunction

    // Called on a negedge; leaves on a negedge. new_ang is applied mid-frame so DONE samples it.
    task automatic spi_frame(input logic [19:0] cmd, input int half, input int nbits, input int gap,
                             input logic [11:0] new_ang, output logic [31:0] rx);
        rx = '0;
        ss_n_i = 1'b0;
        repeat (half) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            sck_i  = 1'b0;
            mosi_i = (i < 20) ? cmd[19-i] : 1'b0;
            if (i == 10) angle_i = new_ang;
            repeat (half) @(negedge clock);
            if (i == 0) check("miso_oe_active", {31'b0, miso_oe}, 32'd1);
            rx    = {rx[30:0], miso_o};
            sck_i = 1'b1;
            repeat (half) @(negedge clock);
        end
        ss_n_i = 1'b1;
        repeat (gap) @(negedge clock);
    endtask

    task automatic run_frame(input logic [19:0] cmd, input int half, input int gap,
                             input logic [11:0] new_ang);
        logic [31:0] rx;
        logic [19:0] exp;
        exp_q.push_back(model_shadow);
        spi_frame(cmd, half, 20, gap, new_ang, rx);
        if (exp_q.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
        else begin
            exp = exp_q.pop_front();
            check("miso_response", {12'b0, rx[19:0]}, {12'b0, exp});
            check("miso_crc", {28'b0, rx[3:0]}, {28'b0, tb_crc(rx[19:4])});
        end
        model_shadow = exp_resp(cmd, angle_i, turns_i);
    endtask

    initial begin
        logic [31:0] rx;
        logic [19:0] pre;
        int          v0;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_miso",    {31'b0, miso_o},      32'd0);
        check("rst_miso_oe", {31'b0, miso_oe},     32'd0);
        check("rst_cmd",     {12'b0, cmd_o},       32'd0);
        check("rst_valid",   {31'b0, cmd_valid_o}, 32'd0);
        check("rst_abort",   {16'b0, abort_count_o}, 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        model_shadow = {16'h0000, tb_crc(16'h0000)};

        // angle command, then turns, error and angle again at both SCK rates
        run_frame(20'h20009, 4, 8, 12'h123);
        check("cmd_angle", {12'b0, cmd_o}, 32'h20009);
        check("vld_1", vld_cnt, 1);
        turns_i = 12'h005;
        run_frame(20'h2C001, 8, 8, 12'h123);
        check("cmd_turns", {12'b0, cmd_o}, 32'h2C001);
        check("vld_2", vld_cnt, 2);
        run_frame(20'h12345, 4, 8, 12'h123);
        check("cmd_err", {12'b0, cmd_o}, 32'h12345);
        run_frame(20'h20009, 8, 8, 12'h123);
        check("miso_oe_idle", {31'b0, miso_oe}, 32'd0);

        // abort after 11 bits keeps shadow, cmd_o and valid count
        v0  = vld_cnt;
        pre = model_shadow;
        spi_frame(20'h2C001, 4, 11, 8, 12'h123, rx);
        check("abort_count", {16'b0, abort_count_o}, 32'd1);
        check("abort_no_vld", vld_cnt, v0);
        check("abort_cmd_hold", {12'b0, cmd_o}, 32'h20009);
        check("abort_shadow_kept", {12'b0, model_shadow}, {12'b0, pre});
        run_frame(20'h2C001, 4, 8, 12'h123);

        // extra SCK edges: response intact, trailing bits zero, command uncorrupted
        exp_q.push_back(model_shadow);
        spi_frame(20'h2C001, 4, 22, 8, 12'h123, rx);
        check("extra_resp", {12'b0, rx[21:2]}, {12'b0, exp_q.pop_front()});
        check("extra_bits_zero", {30'b0, rx[1:0]}, 32'd0);
        check("extra_cmd", {12'b0, cmd_o}, 32'h2C001);
        model_shadow = exp_resp(20'h2C001, angle_i, turns_i);

        // back-to-back frames with a single-cycle SS gap
        v0 = vld_cnt;
        run_frame(20'h20009, 4, 1, 12'h456);
        run_frame(20'h20009, 4, 1, 12'h789);
        run_frame(20'h20009, 8, 1, 12'hABC);
        run_frame(20'h12345, 4, 8, 12'hABC);
        check("b2b_vld", vld_cnt, v0 + 4);
        run_frame(20'h20009, 4, 8, 12'hABC);

        // reset in mid-frame with SS held low across release
        ss_n_i = 1'b0;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            sck_i = 1'b0; repeat (4) @(negedge clock);
            sck_i = 1'b1; repeat (4) @(negedge clock);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("midrst_cmd",   {12'b0, cmd_o},         32'd0);
        check("midrst_abort", {16'b0, abort_count_o}, 32'd0);
        check("midrst_valid", {31'b0, cmd_valid_o},   32'd0);
        check("midrst_miso",  {31'b0, miso_o},        32'd0);
        reset = 1'b0;
        v0 = vld_cnt;
        repeat (10) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            sck_i = 1'b0; repeat (4) @(negedge clock);
            sck_i = 1'b1; repeat (4) @(negedge clock);
        end
        ss_n_i = 1'b1;
        repeat (10) @(negedge clock);
        check("no_stale_frame_abort", {16'b0, abort_count_o}, 32'd0);
        check("no_stale_frame_vld", vld_cnt, v0);
        model_shadow = {16'h0000, tb_crc(16'h0000)};
        run_frame(20'h12345, 8, 8, 12'hABC);
        check("post_rst_cmd", {12'b0, cmd_o}, 32'h12345);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/a1339_emulator.md
A1339_EMULATOR -- requirements
Module: a1339_emulator

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 20, the SPI frame length in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on sck_i, ss_n_i and mosi_i.
REQ-003 SHALL have the port list below; one clock, reset asynchronous and active-high.
- clock  in  1  system clock, at least 8x the SCK frequency
- reset  in  1  asynchronous, active-high
- sck_i  in  1  SPI clock, mode 3 (CPOL=1, CPHA=1), MSB first
- ss_n_i  in  1  slave select, active-low
- mosi_i  in  1  command bits from the master
- miso_o  out  1  response bits to the master
- miso_oe  out  1  MISO drive enable, high while ss_n_i is low (synchronized)
- angle_i  in  12  current emulated angle
- turns_i  in  12  current emulated turns count
- cmd_o  out  20  last complete command frame
- cmd_valid_o  out  1  one-cycle pulse when cmd_o updates
- abort_count_o  out  16  count of frames aborted mid-transfer, wraps

Function
REQ-004 SHALL synchronize sck_i, ss_n_i and mosi_i through SYNC_STAGES flops, and detect SCK rise/fall and SS fall/rise edges from the synchronized signals.
REQ-005 SHALL have FSM states IDLE, SHIFT and DONE.
- IDLE->SHIFT on SS fall
- SHIFT->DONE on SS rise with bit_count==FRAME_BITS
- SHIFT->IDLE on SS rise with bit_count!=FRAME_BITS (abort)
- DONE->IDLE after one cycle
REQ-006 On SS fall, SHALL load tx_shift from tx_shadow, clear rx_shift and clear bit_count.
REQ-007 In SHIFT, on each SCK fall, SHALL drive miso_o from tx_shift[FRAME_BITS-1] and shift tx_shift left by one.
REQ-008 In SHIFT, on each SCK rise, SHALL shift mosi into rx_shift LSB and increment bit_count, saturating at FRAME_BITS.
REQ-009 SCK edges beyond FRAME_BITS SHALL NOT corrupt rx_shift; after FRAME_BITS bits, miso_o SHALL hold 0.
REQ-010 In DONE, SHALL set cmd_o<=rx_shift, pulse cmd_valid_o, and build the next tx_shadow with responses interleaved by one frame:
- rx_shift==CMD_ANGLE (20'h20009): data = {4'h0, angle_i}
- rx_shift==CMD_TURNS (20'h2C001): data = {4'h0, turns_i}
- any other value: data = 16'h8000 (error flag in bit 19)
REQ-011 tx_shadow SHALL be {data[15:0], crc4(data)}.
REQ-012 crc4 SHALL be computed over data MSB first with polynomial x^4+x+1 and initial value 4'hF, using the step D=bit^C3; C3<=C2; C2<=C1; C1<=C0^D; C0<=D.
REQ-013 angle_i and turns_i SHALL be sampled in the DONE cycle only.
REQ-014 On an aborted frame, SHALL increment abort_count_o (wrapping 16'hFFFF->0), leave tx_shadow and cmd_o unchanged, and not pulse cmd_valid_o.
REQ-015 SHALL treat an SS fall in the same cycle as DONE as starting the next frame with the newly built tx_shadow.
REQ-016 miso_oe SHALL equal the inverse of the synchronized ss_n.

Reset
REQ-017 While reset is high, SHALL hold: state=IDLE, miso_o=0, miso_oe=0, cmd_o=0, cmd_valid_o=0, abort_count_o=0, bit_count=0, tx_shift=0.
REQ-018 During reset, SHALL hold tx_shadow=20'h0000D (data 0, valid CRC); synchronizer flops reset to idle levels (sck=1, ss_n=1, mosi=0).
REQ-019 Reset asserted mid-frame SHALL abort the transfer without incrementing abort_count_o; the first frame after reset SHALL start only on a fresh SS fall.

Structure
REQ-020 Package a1339_pkg SHALL hold CMD_ANGLE, CMD_TURNS, ERROR_DATA, the FSM state enum and the crc4 function, shared with the master-side decoder.
REQ-021 Synchronizer plus edge detect SHALL be sub-module spi_slave_sync, instantiated once per input.

Verification
REQ-022 After reset, a first frame with command 20'h20009 SHALL return MISO 20'h0000D; a second frame with angle_i=12'h123 SHALL return {16'h0123, crc4(16'h0123)}.
REQ-023 Command 20'h2C001 with turns_i=12'h005, followed by any frame, SHALL return {16'h0005, crc4}; cmd_o=20'h2C001, with one cmd_valid_o pulse.
REQ-024 Command 20'h12345 SHALL give a next response of {16'h8000, crc4(16'h8000)}.
REQ-025 SS raised after 11 bits SHALL give abort_count_o=1, no cmd_valid_o pulse, and the next frame returning the pre-abort tx_shadow.
REQ-026 Back-to-back frames with a 1-cycle SS gap, with angle_i changed between them, SHALL give each response matching the angle sampled at the previous DONE.
REQ-027 The bench SHALL check every response CRC with the spi_master-side CRC check, at an SCK of clock/8 and at clock/16.
